seq_shift_add_mul: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_shift_add_mul_step.sv | 48 ++++
 rtl/seq_shift_add_mul.sv | 135 +++++++++++++
 tb/tb_seq_shift_add_mul.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
//   state_t   : controller state encoding (IDLE, CALC, DONE)
//   cnt_width : width of the step counter for a given multiplier width
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2(n), never less than one bit so the counter always exists
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_shift_add_mul_step.sv
// One shift-and-add step of the multiplier, purely combinational.
// Optional feature macro: SEQ_SHIFT_ADD_MUL_SIGNED_EN (two's complement
// operation: the final step subtracts the weighted multiplicand).
// Ports:
//   acc      : accumulator before this step
//   mcand    : multiplicand, already extended to product width
//   mbit     : multiplier bit selected for this step
//   index    : step number, used as the shift amount
//   last     : high on the final step (sign-bit weight in signed mode)
//   acc_next : accumulator after this step
module mul_step #(
    parameter int unsigned P_W = 7,
    parameter int unsigned CW  = 2
) (
    input  logic [P_W-1:0] acc,
    input  logic [P_W-1:0] mcand,
    input  logic           mbit,
    input  logic [CW-1:0]  index,
    input  logic           last,
    output logic [P_W-1:0] acc_next
);

    logic [P_W-1:0] term;

    assign term = mcand << index;

`ifdef SEQ_SHIFT_ADD_MUL_SIGNED_EN
    // The multiplier MSB carries weight -2^(B_W-1), so its partial product is subtracted
    always_comb begin
        acc_next = acc;
        if (mbit) begin
            acc_next = last ? (acc - term) : (acc + term);
        end
    end
`else
    logic unused_last;

    assign unused_last = last;

    always_comb begin
        acc_next = acc;
        if (mbit) begin
            acc_next = acc + term;
        end
    end
`endif

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier: one partial product per clock,
// operands in and product out on valid/ready handshakes.
// Optional feature macro: SEQ_SHIFT_ADD_MUL_SIGNED_EN (signed operands/result).
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (a, b)
//   a, b                 : multiplicand (A_W), multiplier (B_W)
//   out_valid / out_ready: result handshake
//   res                  : product (A_W+B_W), held until next completion
//   busy                 : operation in progress or awaiting delivery
module seq_shift_add_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] res,
    output logic               busy
);

    localparam int unsigned P_W = A_W + B_W;
    localparam int unsigned CW  = cnt_width(B_W);

    state_t         state, state_n;
    logic [P_W-1:0] mcand, mcand_n;
    logic [B_W-1:0] mplier, mplier_n;
    logic [P_W-1:0] acc, acc_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [P_W-1:0] res_q, res_n;
    logic           out_valid_q, out_valid_n;
    logic           busy_q, busy_n;
    logic [P_W-1:0] step_acc;
    logic           last;

    assign last = (cnt == CW'(B_W - 1));

    mul_step #(
        .P_W (P_W),
        .CW  (CW)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .mbit     (mplier[cnt]),
        .index    (cnt),
        .last     (last),
        .acc_next (step_acc)
    );

    // Next-state and datapath update
    always_comb begin
        state_n     = state;
        mcand_n     = mcand;
        mplier_n    = mplier;
        acc_n       = acc;
        cnt_n       = cnt;
        res_n       = res_q;
        out_valid_n = out_valid_q;
        busy_n      = busy_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_SHIFT_ADD_MUL_SIGNED_EN
                    mcand_n = {{B_W{a[A_W-1]}}, a};
`else
                    mcand_n = {{B_W{1'b0}}, a};
`endif
                    mplier_n = b;
                    acc_n    = '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = CALC;
                end
            end
            CALC: begin
                acc_n = step_acc;
                cnt_n = cnt + CW'(1);
                if (last) begin
                    res_n       = step_acc;
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                busy_n      = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            mcand       <= mcand_n;
            mplier      <= mplier_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            res_q       <= res_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    // in_ready must read low while reset is held, so it is gated by rst directly
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign res       = res_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed self-checking bench for seq_shift_add_mul: a default 4x3 instance
// for latency, backpressure and reset cases, and an 8x8 instance run
// back-to-back with handshakes tied high.
module tb_seq_shift_add_mul;

    localparam int unsigned A_W  = 4;
    localparam int unsigned B_W  = 3;
    localparam int unsigned P_W  = A_W + B_W;
    localparam int unsigned A2_W = 8;
    localparam int unsigned B2_W = 8;
    localparam int unsigned P2_W = A2_W + B2_W;

`ifdef SEQ_SHIFT_ADD_MUL_SIGNED_EN
    localparam logic [6:0] E_8X7  = 7'd8;     // -8 * -1
    localparam logic [6:0] E_15X7 = 7'd1;     // -1 * -1
    localparam logic [6:0] E_13X3 = 7'h77;    // -3 * 3 = -9
    localparam logic [6:0] E_3X5  = 7'h77;    // 3 * -3 = -9
`else
    localparam logic [6:0] E_8X7  = 7'd56;
    localparam logic [6:0] E_15X7 = 7'd105;
    localparam logic [6:0] E_13X3 = 7'd39;
    localparam logic [6:0] E_3X5  = 7'd15;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready, busy;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [P_W-1:0]  res;
    logic            in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [A2_W-1:0] a2;
    logic [B2_W-1:0] b2;
    logic [P2_W-1:0] res2;

    int compared   = 0;
    int mismatched = 0;

    seq_shift_add_mul #(.A_W(A_W), .B_W(B_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    seq_shift_add_mul #(.A_W(A2_W), .B_W(B2_W)) dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .res       (res2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out(input string tag);
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // One full transaction on the 4x3 instance with latency and handshake checks
    task automatic run_op(input string tag, input logic [3:0] av, input logic [2:0] bv,
                          input logic [6:0] ev);
        int   cyc;
        logic low_ok;
        wait_ready(tag);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        cyc      = 0;
        low_ok   = 1'b1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (in_ready !== 1'b0) low_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (in_ready !== 1'b0) low_ok = 1'b0;
        check({tag, ":latency"}, 32'(cyc), B_W);
        check({tag, ":res"}, 32'(res), 32'(ev));
        check({tag, ":in_ready_low"}, 32'(low_ok), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":post_busy"}, 32'(busy), 32'd0);
        check({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ":res_held"}, 32'(res), 32'(ev));
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_SHIFT_ADD_MUL_SIGNED_EN
        return 16'(int'($signed(x)) * int'($signed(y)));
`else
        return 16'(x) * 16'(y);
`endif
    endfunction

    initial begin
        logic        stable;
        logic [15:0] exp2;
        int          occ;
        int          g;
        logic        seen;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a2         = '0;
        b2         = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst:in_ready", 32'(in_ready), 32'd0);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:res", 32'(res), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release:in_ready", 32'(in_ready), 32'd1);

        run_op("m8x7", 4'd8, 3'd7, E_8X7);
        run_op("m15x7", 4'd15, 3'd7, E_15X7);
        run_op("m0x5", 4'd0, 3'd5, 7'd0);
        run_op("m9x0", 4'd9, 3'd0, 7'd0);
        run_op("m13x3", 4'd13, 3'd3, E_13X3);

        // Backpressure: result held while out_ready low, new operands ignored
        wait_ready("bp");
        a        = 4'd3;
        b        = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        a = 4'd2;
        b = 3'd2;
        wait_out("bp");
        check("bp:res", 32'(res), 32'(E_3X5));
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || res !== E_3X5 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp:held", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp:idle_busy", 32'(busy), 32'd0);
        check("bp:idle_res", 32'(res), 32'(E_3X5));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp:reaccept_busy", 32'(busy), 32'd1);
        wait_out("bp2");
        check("bp2:res", 32'(res), 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of CALC
        wait_ready("rc");
        a        = 4'd7;
        b        = 3'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rc:out_valid", 32'(out_valid), 32'd0);
        check("rc:res", 32'(res), 32'd0);
        check("rc:busy", 32'(busy), 32'd0);
        check("rc:in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rc:release_in_ready", 32'(in_ready), 32'd1);
        run_op("m6x3", 4'd6, 3'd3, 7'd18);

        // Wide instance back-to-back with both handshakes tied high
        a2         = 8'hFF;
        b2         = 8'hFF;
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        for (int op = 0; op < 6; op++) begin
            g = 0;
            while (in_ready2 !== 1'b1 && g < 40) begin
                @(negedge clk);
                g++;
            end
            check("b2b:in_ready", 32'(in_ready2), 32'd1);
            exp2 = model(a2, b2);
            @(negedge clk);
            a2   = 8'($urandom);
            b2   = 8'($urandom);
            occ  = 0;
            seen = 1'b0;
            while (in_ready2 !== 1'b1 && occ < 40) begin
                if (out_valid2 === 1'b1 && !seen) begin
                    check("b2b:res", 32'(res2), 32'(exp2));
                    seen = 1'b1;
                end
                @(negedge clk);
                occ++;
            end
            check("b2b:delivered", 32'(seen), 32'd1);
            check("b2b:occupancy", 32'(occ), B2_W + 1);
        end
        in_valid2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
